btn_event_gen: RTL and testbench
================================

# btn_event_gen

Conditions the raw, bouncy, active-low push-buttons on the board into the clean signals consumed by the stopwatch/timer FSMs. It is the producer side of the button interface:
- `o_Btn_n` gives debounced active-low levels that downstream logic can falling-edge detect itself.
- Single-cycle event strobes (press, release, long-press, auto-repeat) are also provided for blocks that want ready-made events.

Each button channel is independent: 2-flop synchronizer, debounce FSM and hold/repeat counter.

## Interface
- `N_BTN`, 3: number of button channels (start, stop, record).
- `DEB_CYC`, 1_000_000: stable cycles required to accept a level change (10 ms at 100 MHz); must be at least 2.
- `LONG_CYC`, 100_000_000: cycles from accepted press to long-press event (1 s).
- `REP_CYC`, 20_000_000: auto-repeat period after long-press (200 ms).

Ports:
- `i_Clk` in 1: system clock.
- `i_Rst` in 1: synchronous, active-low reset. One clock; all state is updated only on the `i_Clk` rising edge.
- `i_Btn_n` in N_BTN: raw button pins, active-low, asynchronous.
- `o_Btn_n` out N_BTN: debounced level, active-low. Reset value all 1.
- `o_fPress` out N_BTN: 1-cycle strobe on accepted press. Reset value 0.
- `o_fRelease` out N_BTN: 1-cycle strobe on accepted release. Reset value 0.
- `o_fLong` out N_BTN: 1-cycle strobe when the press has been held for LONG_CYC. Reset value 0.
- `o_fRepeat` out N_BTN: 1-cycle strobe every REP_CYC while still held after long. Reset value 0.

## Operation
- **Synchronizer:** 2 flops per channel, reset to 1. The FSM sees only the synced bit `s`.
- **Counters:** one counter per channel, sized `$clog2(max(DEB_CYC,LONG_CYC,REP_CYC))` bits. It is cleared on every state entry and never wraps past its terminal value.
- **Per-channel states:** REL, PWAIT, PRS, HELD, RWAIT, plus a `long` flag bit.
  - **REL:**
    - `o_Btn_n`=1.
    - s=0 → PWAIT.
  - **PWAIT:**
    - s=1 → REL, with no strobe (glitch rejected).
    - Otherwise count. At cnt==DEB_CYC-1 → PRS: set `o_Btn_n`=0, pulse `o_fPress`, clear `long`.
  - **PRS:**
    - s=1 → RWAIT.
    - Else at cnt==LONG_CYC-1 → HELD: pulse `o_fLong`, set `long`.
  - **HELD:**
    - s=1 → RWAIT.
    - Else at cnt==REP_CYC-1: pulse `o_fRepeat` and clear cnt; stay in HELD.
  - **RWAIT:**
    - `o_Btn_n` stays 0.
    - s=0 (bounce) → HELD if `long` is set, else PRS. Counter is cleared and no strobe is issued.
    - At cnt==DEB_CYC-1 with s=1 → REL: set `o_Btn_n`=1, pulse `o_fRelease`.
- **Output registers:** all outputs are registered. Strobes are high for exactly one cycle and never overlap within a channel.
- **Channel independence:** channels never interact. Strobes on different channels in the same cycle are legal and all are reported.
- **Press/release pairing:** every `o_fPress` is followed by exactly one `o_fRelease` before the next `o_fPress`.

## Timing
- **Press latency:** raw low first sampled at edge 1 and held stable → `o_fPress` and `o_Btn_n`=0 are updated at edge DEB_CYC+3 (2 sync + 1 entry + DEB_CYC count).
- **Release latency:** identical, DEB_CYC+3 edges from raw rise.
- **Long-press:** `o_fLong` is asserted exactly LONG_CYC cycles after `o_fPress`.
- **Repeat:** first `o_fRepeat` is REP_CYC cycles after `o_fLong`, then every REP_CYC cycles.
- **Glitches:** a low glitch shorter than DEB_CYC synced cycles produces no output change.
- **Reset mid-operation:**
  - At the reset edge: all channels → REL, sync flops = 1, outputs = reset values, no strobe.
  - A button held through reset is re-detected as a fresh press, DEB_CYC+3 edges after `i_Rst` deasserts.
- **Release during PWAIT:** abort with no output.
- **Release before LONG_CYC:** no `o_fLong`.

## Structure
- **Package `btn_evt_pkg`:** state encodings (REL, PWAIT, PRS, HELD, RWAIT; 3 bits) and the default cycle constants for 100 MHz.
- **Sub-module `btn_channel`:** one per button, containing synchronizer, FSM, counter and the four strobes. It is instantiated N_BTN times with a generate loop in `btn_event_gen`. The top level only slices the buses.

## Test plan
Sim parameters: DEB_CYC=4, LONG_CYC=20, REP_CYC=8.
1. Reset with buttons idle (1) → `o_Btn_n`=3'b111 and all strobes 0. Drive ch0 low cleanly → `o_fPress[0]` is a 1-cycle pulse at edge 7. Release → `o_fRelease[0]` at edge 7 after the rise.
2. Ch1 bounce 1-0-1-0 in 1-cycle steps, then steady 0 → exactly one `o_fPress[1]`, 7 edges after the last falling edge. A 3-cycle low glitch alone → no strobe and `o_Btn_n[1]` stays 1.
3. Ch2 held 60 cycles → `o_fPress`, then `o_fLong` 20 cycles later, then `o_fRepeat` at +8, +16, +24 and +32 cycles after `o_fLong`. Release → `o_fRelease` and no further repeats.
4. Ch0 held with a 2-cycle high bounce inside HELD → no `o_fRelease`, no second `o_fLong`, and the repeat cadence restarts 8 cycles after the bounce.
5. Ch0 and ch2 pressed on the same edge → `o_fPress`=3'b101 in a single cycle.
6. Assert `i_Rst` while ch1 is in HELD → at the reset edge outputs return to reset values. Keep ch1 low and deassert → new `o_fPress[1]` at edge 7 after deassertion.

Source files
------------

// File: rtl/btn_event_gen_pkg.sv
// Shared state encodings, default 100 MHz timing constants and counter sizing
// helpers for the button event generator.
package btn_evt_pkg;

    localparam logic [2:0] ST_REL   = 3'd0;
    localparam logic [2:0] ST_PWAIT = 3'd1;
    localparam logic [2:0] ST_PRS   = 3'd2;
    localparam logic [2:0] ST_HELD  = 3'd3;
    localparam logic [2:0] ST_RWAIT = 3'd4;

    localparam int DEF_DEB_CYC  = 1_000_000;
    localparam int DEF_LONG_CYC = 100_000_000;
    localparam int DEF_REP_CYC  = 20_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The counter only ever has to reach (longest period - 1).
    function automatic int cnt_width(input int deb, input int lng, input int rep);
        return $clog2(max3(deb, lng, rep));
    endfunction

endpackage

// File: rtl/btn_event_gen_if.sv
// Per-channel event bundle driven by a button channel and read by its consumer.
// Strobes are registered one-cycle pulses with no back-pressure: a consumer
// must sample them every cycle; btn_n is a level and may be sampled at will.
interface btn_evt_if #(
    parameter int N = 1
);
    logic [N-1:0] btn_n;
    logic [N-1:0] f_press;
    logic [N-1:0] f_release;
    logic [N-1:0] f_long;
    logic [N-1:0] f_repeat;

    modport master (output btn_n, f_press, f_release, f_long, f_repeat);
    modport slave  (input  btn_n, f_press, f_release, f_long, f_repeat);
endinterface

// File: rtl/btn_event_gen_channel.sv
// One button channel: 2-flop synchronizer, debounce/hold FSM with a single
// saturating counter, debounced level and four one-cycle event strobes.
module btn_channel
    import btn_evt_pkg::*;
#(
    parameter int DEB_CYC  = DEF_DEB_CYC,
    parameter int LONG_CYC = DEF_LONG_CYC,
    parameter int REP_CYC  = DEF_REP_CYC
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Btn_n,
    btn_evt_if.master   evt
);

    localparam int            CW      = cnt_width(DEB_CYC, LONG_CYC, REP_CYC);
    localparam logic [CW-1:0] DEB_T   = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0] LONG_T  = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] REP_T   = CW'(REP_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [1:0]    r_sync;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_long;
    logic          r_btn_n;
    logic          r_press;
    logic          r_release;
    logic          r_flong;
    logic          r_repeat;

    logic          w_s;
    logic [CW-1:0] w_cnt_inc;

    assign w_s       = r_sync[1];
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            r_sync    <= 2'b11;
            r_state   <= ST_REL;
            r_cnt     <= '0;
            r_long    <= 1'b0;
            r_btn_n   <= 1'b1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_flong   <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_Btn_n};
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_flong   <= 1'b0;
            r_repeat  <= 1'b0;
            case (r_state)
                ST_REL: begin
                    if (!w_s) begin
                        r_state <= ST_PWAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_PWAIT: begin
                    if (w_s) begin
                        r_state <= ST_REL;
                        r_cnt   <= '0;
                    end else if (r_cnt == DEB_T) begin
                        r_state <= ST_PRS;
                        r_cnt   <= '0;
                        r_btn_n <= 1'b0;
                        r_press <= 1'b1;
                        r_long  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_PRS: begin
                    if (w_s) begin
                        r_state <= ST_RWAIT;
                        r_cnt   <= '0;
                    end else if (r_cnt == LONG_T) begin
                        r_state <= ST_HELD;
                        r_cnt   <= '0;
                        r_flong <= 1'b1;
                        r_long  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (w_s) begin
                        r_state <= ST_RWAIT;
                        r_cnt   <= '0;
                    end else if (r_cnt == REP_T) begin
                        r_cnt    <= '0;
                        r_repeat <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_RWAIT: begin
                    // A low bounce resumes the hold phase silently with a fresh count.
                    if (!w_s) begin
                        r_state <= r_long ? ST_HELD : ST_PRS;
                        r_cnt   <= '0;
                    end else if (r_cnt == DEB_T) begin
                        r_state   <= ST_REL;
                        r_cnt     <= '0;
                        r_btn_n   <= 1'b1;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= ST_REL;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign evt.btn_n     = r_btn_n;
    assign evt.f_press   = r_press;
    assign evt.f_release = r_release;
    assign evt.f_long    = r_flong;
    assign evt.f_repeat  = r_repeat;

endmodule

// File: rtl/btn_event_gen.sv
// Button conditioning top: N_BTN independent channels whose per-channel
// event bundles are sliced onto the output buses.
module btn_event_gen
    import btn_evt_pkg::*;
#(
    parameter int N_BTN    = 3,
    parameter int DEB_CYC  = DEF_DEB_CYC,
    parameter int LONG_CYC = DEF_LONG_CYC,
    parameter int REP_CYC  = DEF_REP_CYC
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic [N_BTN-1:0] i_Btn_n,
    output logic [N_BTN-1:0] o_Btn_n,
    output logic [N_BTN-1:0] o_fPress,
    output logic [N_BTN-1:0] o_fRelease,
    output logic [N_BTN-1:0] o_fLong,
    output logic [N_BTN-1:0] o_fRepeat
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_evt_if #(.N(1)) u_evt ();

        btn_channel #(
            .DEB_CYC  (DEB_CYC),
            .LONG_CYC (LONG_CYC),
            .REP_CYC  (REP_CYC)
        ) u_ch (
            .i_Clk   (i_Clk),
            .i_Rst   (i_Rst),
            .i_Btn_n (i_Btn_n[g]),
            .evt     (u_evt.master)
        );

        assign o_Btn_n[g]    = u_evt.btn_n[0];
        assign o_fPress[g]   = u_evt.f_press[0];
        assign o_fRelease[g] = u_evt.f_release[0];
        assign o_fLong[g]    = u_evt.f_long[0];
        assign o_fRepeat[g]  = u_evt.f_repeat[0];
    end

endmodule

// File: tb/tb_btn_event_gen.sv
// Bench for btn_event_gen: a run-length/timestamp model of the debounce and
// hold rules checked every cycle, plus directed timing checks and random bounce.
module tb_btn_event_gen;
    import btn_evt_pkg::*;

    localparam int N    = 3;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;
    localparam int K_REP   = 3;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn_n = '1;
    logic [N-1:0] o_Btn_n, o_fPress, o_fRelease, o_fLong, o_fRepeat;

    always #5 clk = ~clk;

    btn_event_gen #(
        .N_BTN    (N),
        .DEB_CYC  (DEB),
        .LONG_CYC (LONG),
        .REP_CYC  (REP)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst_n),
        .i_Btn_n    (btn_n),
        .o_Btn_n    (o_Btn_n),
        .o_fPress   (o_fPress),
        .o_fRelease (o_fRelease),
        .o_fLong    (o_fLong),
        .o_fRepeat  (o_fRepeat)
    );

    btn_evt_if #(.N(N)) mon ();
    assign mon.btn_n     = o_Btn_n;
    assign mon.f_press   = o_fPress;
    assign mon.f_release = o_fRelease;
    assign mon.f_long    = o_fLong;
    assign mon.f_repeat  = o_fRepeat;

    int vectors    = 0;
    int miscompares = 0;
    int ecnt       = 0;

    // ---------------- reference model ----------------
    // Debounce as run lengths of the synced level; hold events as time elapsed
    // since the most recent anchor (press, long, or return from a high bounce).
    logic [N-1:0] m_btn_n, m_press, m_rel, m_long, m_rep;
    bit           m_valid = 1'b0;
    logic [N-1:0] m_hist[$];
    bit           m_run_val[N];
    int           m_run_len[N];
    bit           m_long_seen[N];
    int           m_anchor[N];

    always @(posedge clk) begin : model
        logic [N-1:0] s;
        ecnt++;
        if (!rst_n) begin
            m_valid = 1'b1;
            m_hist.delete();
            m_hist.push_back('1);
            m_hist.push_back('1);
            m_btn_n = '1;
            m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
            for (int c = 0; c < N; c++) begin
                m_run_val[c] = 1'b1; m_run_len[c] = 0;
                m_long_seen[c] = 1'b0; m_anchor[c] = 0;
            end
        end else begin
            s = m_hist.pop_front();
            m_hist.push_back(btn_n);
            m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
            for (int c = 0; c < N; c++) begin
                if (s[c] == m_run_val[c]) m_run_len[c]++;
                else begin m_run_val[c] = s[c]; m_run_len[c] = 1; end
                if (m_btn_n[c]) begin
                    if (!s[c] && m_run_len[c] == DEB + 1) begin
                        m_btn_n[c] = 1'b0; m_press[c] = 1'b1;
                        m_long_seen[c] = 1'b0; m_anchor[c] = ecnt;
                    end
                end else if (s[c]) begin
                    if (m_run_len[c] == DEB + 1) begin
                        m_btn_n[c] = 1'b1; m_rel[c] = 1'b1;
                    end
                end else if (m_run_len[c] == 1) begin
                    m_anchor[c] = ecnt;
                end else if (!m_long_seen[c]) begin
                    if (ecnt - m_anchor[c] == LONG) begin
                        m_long[c] = 1'b1; m_long_seen[c] = 1'b1; m_anchor[c] = ecnt;
                    end
                end else if ((ecnt - m_anchor[c]) % REP == 0) begin
                    m_rep[c] = 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    int ev_q[$];

    always @(negedge clk) begin
        if (m_valid) begin
            vectors++;
            if ({mon.btn_n, mon.f_press, mon.f_release, mon.f_long, mon.f_repeat} !==
                {m_btn_n, m_press, m_rel, m_long, m_rep}) begin
                miscompares++;
                if (miscompares <= 20)
                    $display("FAIL outputs edge %0d: got btn_n=%b press=%b rel=%b long=%b rep=%b, expected btn_n=%b press=%b rel=%b long=%b rep=%b",
                             ecnt, mon.btn_n, mon.f_press, mon.f_release, mon.f_long, mon.f_repeat,
                             m_btn_n, m_press, m_rel, m_long, m_rep);
            end
            for (int c = 0; c < N; c++) begin
                if (mon.f_press[c]   === 1'b1) ev_q.push_back(ecnt * 16 + K_PRESS * 4 + c);
                if (mon.f_release[c] === 1'b1) ev_q.push_back(ecnt * 16 + K_REL * 4 + c);
                if (mon.f_long[c]    === 1'b1) ev_q.push_back(ecnt * 16 + K_LONG * 4 + c);
                if (mon.f_repeat[c]  === 1'b1) ev_q.push_back(ecnt * 16 + K_REP * 4 + c);
            end
        end
    end

    function automatic int first_ev(input int kind, input int ch, input int from, input int upto);
        foreach (ev_q[i]) begin
            if ((ev_q[i] % 16) == kind * 4 + ch && ev_q[i] / 16 >= from && ev_q[i] / 16 <= upto)
                return ev_q[i] / 16;
        end
        return -1;
    endfunction

    function automatic int count_ev(input int kind, input int ch, input int from, input int upto);
        int n = 0;
        foreach (ev_q[i]) begin
            if ((ev_q[i] % 16) == kind * 4 + ch && ev_q[i] / 16 >= from && ev_q[i] / 16 <= upto)
                n++;
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int ch, input logic v);
        btn_n[ch] = v;
    endtask

    // ---------------- stimulus ----------------
    int e, el, er;
    int hold_left[N];

    initial begin
        rst_n = 1'b0;
        btn_n = '1;
        cyc(3);
        chk("rst_btn_n", int'(o_Btn_n), 7);
        chk("rst_strobes", int'({o_fPress, o_fRelease, o_fLong, o_fRepeat}), 0);
        rst_n = 1'b1;
        cyc(2);

        // 1: clean press/release on ch0
        e = ecnt; set_btn(0, 1'b0); cyc(12);
        chk("t1_press_edge", first_ev(K_PRESS, 0, e, ecnt) - e, 7);
        chk("t1_press_count", count_ev(K_PRESS, 0, e, ecnt), 1);
        chk("t1_level_low", int'(o_Btn_n[0]), 0);
        e = ecnt; set_btn(0, 1'b1); cyc(12);
        chk("t1_release_edge", first_ev(K_REL, 0, e, ecnt) - e, 7);

        // 2: bounce then steady low on ch1, then a short glitch
        e = ecnt;
        set_btn(1, 1'b0); cyc(1);
        set_btn(1, 1'b1); cyc(1);
        set_btn(1, 1'b0); el = ecnt; cyc(12);
        chk("t2_press_edge", first_ev(K_PRESS, 1, e, ecnt) - el, 7);
        chk("t2_press_count", count_ev(K_PRESS, 1, e, ecnt), 1);
        set_btn(1, 1'b1); cyc(10);
        e = ecnt; set_btn(1, 1'b0); cyc(3); set_btn(1, 1'b1); cyc(12);
        chk("t2_glitch_press", count_ev(K_PRESS, 1, e, ecnt), 0);
        chk("t2_glitch_level", int'(o_Btn_n[1]), 1);

        // 3: ch2 long hold with repeats
        e = ecnt; set_btn(2, 1'b0); cyc(60); set_btn(2, 1'b1); cyc(12);
        chk("t3_press_edge", first_ev(K_PRESS, 2, e, ecnt) - e, 7);
        chk("t3_long_edge", first_ev(K_LONG, 2, e, ecnt) - e, 27);
        chk("t3_long_count", count_ev(K_LONG, 2, e, ecnt), 1);
        for (int n = 1; n <= 4; n++)
            chk($sformatf("t3_repeat%0d_edge", n),
                first_ev(K_REP, 2, e + 27 + 8 * (n - 1) + 1, ecnt) - e, 27 + 8 * n);
        chk("t3_repeat_count", count_ev(K_REP, 2, e, ecnt), 4);
        chk("t3_release_edge", first_ev(K_REL, 2, e, ecnt) - e, 67);

        // 4: ch0 high bounce inside HELD
        e = ecnt; set_btn(0, 1'b0); cyc(37);
        set_btn(0, 1'b1); cyc(2);
        set_btn(0, 1'b0); cyc(16);
        set_btn(0, 1'b1); cyc(12);
        chk("t4_repeat1_edge", first_ev(K_REP, 0, e, ecnt) - e, 35);
        chk("t4_repeat2_edge", first_ev(K_REP, 0, e + 36, ecnt) - e, 50);
        chk("t4_repeat_count", count_ev(K_REP, 0, e, ecnt), 2);
        chk("t4_long_count", count_ev(K_LONG, 0, e, ecnt), 1);
        chk("t4_no_early_release", count_ev(K_REL, 0, e, e + 55), 0);
        chk("t4_release_edge", first_ev(K_REL, 0, e, ecnt) - e, 62);

        // 5: ch0 and ch2 pressed together
        btn_n = 3'b010; cyc(7);
        chk("t5_press_vec", int'(o_fPress), 5);
        btn_n = '1; cyc(12);

        // 6: reset while ch1 is in HELD, button kept low
        set_btn(1, 1'b0); cyc(30);
        rst_n = 1'b0; cyc(1);
        chk("t6_rst_btn_n", int'(o_Btn_n), 7);
        chk("t6_rst_strobes", int'({o_fPress, o_fRelease, o_fLong, o_fRepeat}), 0);
        rst_n = 1'b1; er = ecnt; cyc(12);
        chk("t6_repress_edge", first_ev(K_PRESS, 1, er, ecnt) - er, 7);
        set_btn(1, 1'b1); cyc(12);

        // random bouncy segments per channel with rare resets
        for (int c = 0; c < N; c++) hold_left[c] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++) begin
                if (hold_left[c] == 0) begin
                    btn_n[c] = 1'($urandom_range(0, 1));
                    hold_left[c] = $urandom_range(1, 35);
                end
                hold_left[c]--;
            end
            rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
            cyc(1);
        end
        rst_n = 1'b1;
        btn_n = '1;
        cyc(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
